// File: rtl/branch_redirect_ctrl_if.sv
// Purpose: bundles the EX-side request, fetch handshake and redirect controls of branch_redirect_ctrl.
// Latency: none. This is a wiring bundle only.
// Backpressure: if_ready is the fetch-side ready. A pending redirect waits until it is high.
//
// Ports (signals):
//   ex_valid, ex_pc_sel, ex_br_pc  EX-stage redirect request and target (master -> slave)
//   if_ready                       fetch accepts a PC load this cycle (master -> slave)
//   pc_load, pc_target             PC register load strobe and registered target (slave -> master)
//   flush_ifid, flush_idex         pipeline register clears (slave -> master)
//   kill_ex, busy                  wrong-path EX kill and redirect-pending flag (slave -> master)
//   err, redirect_count            sticky target errors and saturating redirect count (slave -> master)
interface branch_redirect_ctrl_if #(
   parameter int PC_W = 9
);
   logic            ex_valid;
   logic            ex_pc_sel;
   logic [31:0]     ex_br_pc;
   logic            if_ready;
   logic            pc_load;
   logic [PC_W-1:0] pc_target;
   logic            flush_ifid;
   logic            flush_idex;
   logic            kill_ex;
   logic            busy;
   logic [1:0]      err;
   logic [15:0]     redirect_count;

   // The master side is the pipeline: EX branch logic plus the fetch unit.
   modport master (
      output ex_valid, ex_pc_sel, ex_br_pc, if_ready,
      input  pc_load, pc_target, flush_ifid, flush_idex, kill_ex, busy, err, redirect_count
   );

   // The slave side is the redirect controller.
   modport slave (
      input  ex_valid, ex_pc_sel, ex_br_pc, if_ready,
      output pc_load, pc_target, flush_ifid, flush_idex, kill_ex, busy, err, redirect_count
   );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Purpose: captures an EX-resolved redirect and holds it until fetch takes the new PC, squashing wrong-path work.
// Latency: an accept at edge N gives pc_load, flush and kill in cycle N+1 when if_ready is high.
// Backpressure: each low if_ready cycle while pending adds one cycle. Flush and kill stay high throughout.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset. It has priority over all other inputs.
//   bus    branch_redirect_ctrl_if.slave. The request and fetch handshake come in; the redirect controls go out.
module branch_redirect_ctrl #(
   parameter int PC_W = 9
) (
   input logic                  clk,
   input logic                  reset,
   branch_redirect_ctrl_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] tgt_q, tgt_d;
   logic [1:0]      err_q, err_d;
   logic [15:0]     redirect_cnt_q, redirect_cnt_d;

   logic req;
   logic misaligned;
   logic out_of_range;

   assign req          = bus.ex_valid & bus.ex_pc_sel;
   assign misaligned   = |bus.ex_br_pc[1:0];
   // Fetch PC is only PC_W bits wide, so any upper target bit means the target is unreachable.
   assign out_of_range = |bus.ex_br_pc[31:PC_W];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         tgt_q          <= '0;
         err_q          <= '0;
         redirect_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         tgt_q          <= tgt_d;
         err_q          <= err_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d        = state_q;
      tgt_d          = tgt_q;
      err_d          = err_q;
      redirect_cnt_d = redirect_cnt_q;
      if (state_q == IDLE) begin
         if (req) begin
            if (!misaligned && !out_of_range) begin
               state_d = PEND;
               tgt_d   = bus.ex_br_pc[PC_W-1:0];
            end else begin
               // An illegal request is dropped. Only its error causes are recorded, and they are sticky.
               err_d = err_q | {out_of_range, misaligned};
            end
         end
      end else begin
         // The EX request is ignored here because EX holds a wrong-path instruction.
         if (bus.if_ready) begin
            state_d = IDLE;
            if (redirect_cnt_q != 16'hFFFF) begin
               redirect_cnt_d = redirect_cnt_q + 16'd1;
            end
         end
      end
   end

   // Output logic. pc_load is the only output that is not purely registered.
   always_comb begin
      bus.pc_load        = 1'b0;
      bus.flush_ifid     = 1'b0;
      bus.flush_idex     = 1'b0;
      bus.kill_ex        = 1'b0;
      bus.busy           = 1'b0;
      bus.pc_target      = tgt_q;
      bus.err            = err_q;
      bus.redirect_count = redirect_cnt_q;
      if (state_q == PEND) begin
         bus.pc_load    = bus.if_ready;
         bus.flush_ifid = 1'b1;
         bus.flush_idex = 1'b1;
         bus.kill_ex    = 1'b1;
         bus.busy       = 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Purpose: self-checking bench for branch_redirect_ctrl. It uses directed vectors, a reset and saturation sequence, and random traffic against a reference model.
// Latency: inputs are driven after the falling edge and outputs are sampled 1 ns later, before the next rising edge.
// Backpressure: if_ready is driven directly, either from the vector table or at random.
module tb_branch_redirect_ctrl;

   localparam int PC_W = 9;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   branch_redirect_ctrl_if #(.PC_W(PC_W)) bus_if();

   branch_redirect_ctrl #(.PC_W(PC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          vld;
      bit          sel;
      logic [31:0] pc;
      bit          rdy;
      bit          e_load;
      bit          e_busy;
      logic [8:0]  e_tgt;
      logic [1:0]  e_err;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tv[20];

   // The reference model holds only the redirect facts: whether one is pending, and where it goes.
   bit          m_pending;
   logic [8:0]  m_tgt;
   logic [1:0]  m_err;
   int unsigned m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input bit r, input bit v, input bit s, input logic [31:0] pc, input bit rdy);
      @(negedge clk);
      reset            = r;
      bus_if.ex_valid  = v;
      bus_if.ex_pc_sel = s;
      bus_if.ex_br_pc  = pc;
      bus_if.if_ready  = rdy;
      #1;
   endtask

   task automatic check_outs(input string tag, input bit e_load, input bit e_busy,
                             input logic [8:0] e_tgt, input logic [1:0] e_err, input logic [15:0] e_cnt);
      chk({tag, " pc_load"},    {31'd0, bus_if.pc_load},    {31'd0, e_load});
      chk({tag, " busy"},       {31'd0, bus_if.busy},       {31'd0, e_busy});
      chk({tag, " flush_ifid"}, {31'd0, bus_if.flush_ifid}, {31'd0, e_busy});
      chk({tag, " flush_idex"}, {31'd0, bus_if.flush_idex}, {31'd0, e_busy});
      chk({tag, " kill_ex"},    {31'd0, bus_if.kill_ex},    {31'd0, e_busy});
      chk({tag, " pc_target"},  {23'd0, bus_if.pc_target},  {23'd0, e_tgt});
      chk({tag, " err"},        {30'd0, bus_if.err},        {30'd0, e_err});
      chk({tag, " count"},      {16'd0, bus_if.redirect_count}, {16'd0, e_cnt});
   endtask

   task automatic model_reset();
      m_pending = 1'b0;
      m_tgt     = '0;
      m_err     = '0;
      m_cnt     = 0;
   endtask

   // Drive one cycle, compare the DUT against the model's current view, then advance the model past the edge.
   task automatic step(input string tag, input bit r, input bit v, input bit s,
                       input logic [31:0] pc, input bit rdy);
      bit aligned;
      bit reachable;
      apply(r, v, s, pc, rdy);
      check_outs(tag, m_pending && rdy, m_pending, m_tgt, m_err, m_cnt[15:0]);
      aligned   = (pc % 4) == 0;
      reachable = pc < (32'd1 << PC_W);
      if (r) begin
         model_reset();
      end else if (m_pending) begin
         if (rdy) begin
            m_pending = 1'b0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
         end
      end else if (v && s) begin
         if (aligned && reachable) begin
            m_pending = 1'b1;
            m_tgt     = pc[8:0];
         end else begin
            if (!aligned)   m_err[0] = 1'b1;
            if (!reachable) m_err[1] = 1'b1;
         end
      end
   endtask

   initial begin
      logic [31:0] rpc;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus_if.ex_valid  = 1'b0;
      bus_if.ex_pc_sel = 1'b0;
      bus_if.ex_br_pc  = '0;
      bus_if.if_ready  = 1'b0;

      //         rst vld sel pc            rdy  load busy tgt     err    cnt
      tv[0]  = '{0, 0, 0, 32'h0000_0000, 1,   0, 0, 9'h000, 2'b00, 16'd0}; // reset state
      tv[1]  = '{0, 1, 1, 32'h0000_0040, 1,   0, 0, 9'h000, 2'b00, 16'd0}; // accept 0x40
      tv[2]  = '{0, 0, 0, 32'h0000_0000, 1,   1, 1, 9'h040, 2'b00, 16'd0}; // min-latency load
      tv[3]  = '{0, 0, 0, 32'h0000_0000, 1,   0, 0, 9'h040, 2'b00, 16'd1}; // back to IDLE
      tv[4]  = '{0, 1, 1, 32'h0000_0080, 0,   0, 0, 9'h040, 2'b00, 16'd1}; // accept 0x80
      tv[5]  = '{0, 0, 0, 32'h0000_0000, 0,   0, 1, 9'h080, 2'b00, 16'd1}; // stall 1
      tv[6]  = '{0, 1, 1, 32'h0000_0100, 0,   0, 1, 9'h080, 2'b00, 16'd1}; // stall 2 + wrong path
      tv[7]  = '{0, 1, 1, 32'h0000_0100, 0,   0, 1, 9'h080, 2'b00, 16'd1}; // stall 3 + wrong path
      tv[8]  = '{0, 1, 1, 32'h0000_0100, 1,   1, 1, 9'h080, 2'b00, 16'd1}; // load in 4th cycle
      tv[9]  = '{0, 0, 0, 32'h0000_0000, 1,   0, 0, 9'h080, 2'b00, 16'd2}; // exactly +1
      tv[10] = '{0, 1, 1, 32'h0000_0042, 1,   0, 0, 9'h080, 2'b00, 16'd2}; // misaligned
      tv[11] = '{0, 1, 1, 32'h0000_0400, 1,   0, 0, 9'h080, 2'b01, 16'd2}; // out of range
      tv[12] = '{0, 0, 0, 32'h0000_0000, 1,   0, 0, 9'h080, 2'b11, 16'd2}; // no PEND, err=11
      tv[13] = '{0, 1, 0, 32'h0000_0400, 1,   0, 0, 9'h080, 2'b11, 16'd2}; // sel low ignored
      tv[14] = '{0, 0, 1, 32'h0000_0043, 1,   0, 0, 9'h080, 2'b11, 16'd2}; // valid low ignored
      tv[15] = '{0, 1, 1, 32'h0000_01FC, 1,   0, 0, 9'h080, 2'b11, 16'd2}; // top legal target
      tv[16] = '{0, 1, 1, 32'h0000_000C, 1,   1, 1, 9'h1FC, 2'b11, 16'd2}; // load, request ignored
      tv[17] = '{0, 1, 1, 32'h0000_000C, 1,   0, 0, 9'h1FC, 2'b11, 16'd3}; // back-to-back accept
      tv[18] = '{0, 0, 0, 32'h0000_0000, 1,   1, 1, 9'h00C, 2'b11, 16'd3}; // second load
      tv[19] = '{0, 0, 0, 32'h0000_0000, 1,   0, 0, 9'h00C, 2'b11, 16'd4}; // err stays sticky

      apply(1, 0, 0, 32'h0, 0);
      apply(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 20; i++) begin
         apply(tv[i].rst, tv[i].vld, tv[i].sel, tv[i].pc, tv[i].rdy);
         check_outs($sformatf("vec%0d", i), tv[i].e_load, tv[i].e_busy,
                    tv[i].e_tgt, tv[i].e_err, tv[i].e_cnt);
      end

      // Reset in the middle of a stalled redirect.
      apply(1, 0, 0, 32'h0, 0);
      model_reset();
      step("rst_err",   0, 1, 1, 32'h0000_0006, 1); // leaves err[0] set
      step("rst_acc",   0, 1, 1, 32'h0000_0020, 1);
      step("rst_load",  0, 0, 0, 32'h0,         1); // count 1
      step("rst_acc2",  0, 1, 1, 32'h0000_0024, 0);
      step("rst_stall", 0, 0, 0, 32'h0,         0);
      step("rst_pulse", 1, 1, 1, 32'h0000_0030, 0); // reset wins over the request
      step("rst_after", 0, 0, 0, 32'h0,         1);
      chk("rst_cleared_err", {30'd0, bus_if.err}, 32'd0);
      chk("rst_cleared_cnt", {16'd0, bus_if.redirect_count}, 32'd0);
      step("rst_idle1", 0, 0, 0, 32'h0, 1);
      step("rst_idle2", 0, 0, 0, 32'h0, 1);

      // Counter saturation, starting from a forced 16'hFFFE.
      force dut.redirect_cnt_q = 16'hFFFE;
      m_cnt = 32'hFFFE;
      step("sat_force", 0, 0, 0, 32'h0, 1);
      release dut.redirect_cnt_q;
      for (int k = 0; k < 3; k++) begin
         step($sformatf("sat_acc%0d", k),  0, 1, 1, 32'h0000_0010 + 32'(k * 4), 1);
         step($sformatf("sat_load%0d", k), 0, 0, 0, 32'h0, 1);
      end
      step("sat_idle", 0, 0, 0, 32'h0, 1);
      chk("sat_hold", {16'd0, bus_if.redirect_count}, 32'h0000_FFFF);

      // Random traffic checked against the model.
      step("rnd_rst", 1, 0, 0, 32'h0, 0);
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 4))
            0:       rpc = $urandom_range(0, 127) * 4;     // legal
            1:       rpc = $urandom_range(0, 511);         // often misaligned
            2:       rpc = 32'h200 | ($urandom & 32'hFFC); // out of range, aligned
            3:       rpc = $urandom;                       // anything
            default: rpc = 32'h1FC;                        // top legal target
         endcase
         step($sformatf("rnd%0d", n), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 3) != 0), $urandom_range(0, 1), rpc,
              ($urandom_range(0, 2) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences PC redirection for the 5-stage pipeline. It captures a taken branch, JAL or JALR resolved in EX (`PcSel`/`BrPC` from the branch logic) and holds the redirect until instruction fetch can accept it. While the redirect is pending it squashes wrong-path instructions and kills the wrong-path EX instruction. It also flags illegal targets and keeps a saturating count of redirects. It sits between the EX-stage branch logic and the PC register / IF-ID / ID-EX pipeline registers.

## Interface
- `PC_W`, 9, width of the fetch PC; target bits above `PC_W-1` must be zero.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  EX stage holds a real (non-bubble) instruction.
- `ex_pc_sel`  in  1  EX instruction redirects control flow (branch taken, JAL or JALR).
- `ex_br_pc`  in  32  redirect target computed in EX.
- `if_ready`  in  1  fetch accepts a PC load this cycle (low while instruction memory is busy).
- `pc_load`  out  1  load `pc_target` into the PC register this cycle.
- `pc_target`  out  PC_W  registered redirect target.
- `flush_ifid`  out  1  clear IF/ID at the end of this cycle.
- `flush_idex`  out  1  clear ID/EX at the end of this cycle.
- `kill_ex`  out  1  suppress writeback and memory side effects of the current EX instruction.
- `busy`  out  1  redirect pending.
- `err`  out  2  sticky error flags: bit0 = misaligned target, bit1 = target out of range.
- `redirect_count`  out  16  number of completed redirects, saturating.

## Operation
- Two-state FSM: IDLE and PEND. Reset enters IDLE.
- An **accept** occurs in IDLE when `ex_valid & ex_pc_sel` and the target is legal.
  - Legal target: `ex_br_pc[1:0]==0` and `ex_br_pc[31:PC_W]==0`.
  - On accept: latch `tgt_q <= ex_br_pc[PC_W-1:0]` and go to PEND.
- An illegal request in IDLE causes no redirect and stays in IDLE.
  - Misaligned target sets `err[0]`; out-of-range target sets `err[1]`. Both are set if both apply.
  - `err` bits are sticky until reset.
- PEND:
  - `busy=1`, `flush_ifid=1`, `flush_idex=1`, `kill_ex=1` every cycle in this state.
  - `ex_pc_sel` and `ex_valid` are ignored, because the EX instruction is wrong-path.
  - When `if_ready=1`: `pc_load=1` for that cycle only, `redirect_count` increments (holds at 16'hFFFF), and the FSM returns to IDLE.
  - When `if_ready=0`: stay in PEND with no PC load.
- IDLE outputs: `pc_load`, `flush_*`, `kill_ex` and `busy` are all 0.
- `pc_target` is always `tgt_q`. It is meaningful only when `pc_load=1` and holds its value otherwise.
- Reset values: state IDLE, `tgt_q=0`, `err=0`, `redirect_count=0`. All single-bit outputs are 0.

## Timing
- Accept is sampled at the rising edge ending cycle N. PEND starts at N+1.
- Minimum latency (`if_ready` high at N+1): `pc_load`, `flush_ifid`, `flush_idex` and `kill_ex` are all high in N+1. The first correct-path fetch happens at N+2.
- Each low cycle of `if_ready` in PEND adds one cycle, with flush and kill held high throughout.
- A back-to-back request is possible: a valid `ex_pc_sel` in the IDLE cycle immediately after PEND completes is accepted.
- `reset` asserted mid-PEND: next cycle is IDLE with no `pc_load`; `err` and `redirect_count` are cleared.
- `reset` has priority over every other input in the same cycle.
- All outputs are functions of registered state, except `pc_load`, which is `state==PEND & if_ready`.

## Test plan
- Simple redirect:
  - Stimulus: `ex_valid=1`, `ex_pc_sel=1`, `ex_br_pc=32'h0000_0040`, `if_ready=1` at cycle N.
  - Required: at N+1, `pc_load=1`, `pc_target=9'h040`, flush and kill high; `redirect_count=1` after N+1; IDLE at N+2.
- Fetch stall:
  - Stimulus: accept target 0x080; hold `if_ready=0` for 3 cycles, then set it to 1.
  - Required: `busy`, flush and kill high for 4 cycles; `pc_load` only in the 4th cycle; target 0x080.
- Wrong-path suppression:
  - Stimulus: during PEND, drive `ex_pc_sel=1` with `ex_br_pc=0x100`.
  - Required: ignored; `pc_target` stays at the original value; `redirect_count` increases by exactly 1.
- Illegal targets:
  - Stimulus: `ex_br_pc=0x042`, then `ex_br_pc=0x0000_0400` with `PC_W=9`.
  - Required: no PEND; `err` goes 01 then 11 and stays 11 across later legal redirects.
- Reset mid-PEND:
  - Stimulus: accept, `if_ready=0`, assert `reset` for one cycle.
  - Required: IDLE, all outputs 0, `err=0`, `redirect_count=0`; no `pc_load` afterwards.
- Counter saturation:
  - Stimulus: preload 65535 redirects (or force the counter to 16'hFFFE), then do 3 more redirects.
  - Required: `redirect_count` reaches 16'hFFFF and holds there.
